// File: rtl/main_mem_responder_if.sv
// Request/response bundle between a memory requester and main_mem_responder.
// Signal names follow the ADDR/DIN/WE/RREQ/DOUT/RDY memory protocol.
interface main_mem_responder_if;
    logic [31:0] ADDR;
    logic [31:0] DIN;
    logic        WE;
    logic        RREQ;
    logic [31:0] DOUT;
    logic        RDY;

    modport master (
        output ADDR, DIN, WE, RREQ,
        input  DOUT, RDY
    );

    modport slave (
        input  ADDR, DIN, WE, RREQ,
        output DOUT, RDY
    );
endinterface

// File: rtl/main_mem_responder.sv
// Word-addressed backing memory with fixed access latency and edge-detected requests.
// Optional MAIN_MEM_WRITE_ECHO_EN: write completion drives DOUT with the written word.
module main_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 4
) (
    input logic                  CLK,
    input logic                  RST_N,
    main_mem_responder_if.slave  bus
);
    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         din_q, din_d;
    logic                we_q, we_d;
    logic [31:0]         dout_q, dout_d;
    logic [31:0]         mem [DEPTH];

    logic req;
    logic accept;
    logic done;
    logic mem_we;
    logic unused_addr;

    // Upper address bits alias onto the same words.
    assign unused_addr = ^bus.ADDR[31:ADDR_W];

    always_comb begin
        req    = bus.WE | bus.RREQ;
        accept = req & ~req_q & (state_q == S_IDLE);
        done   = (state_q == S_BUSY) && (cnt_q == 8'd0);
        mem_we = done & we_q;
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= 32'd0;
            we_q    <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            dout_q  <= dout_d;
        end
    end

    // Memory has no reset; a write lands only on its completion edge.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[addr_q] <= din_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_BUSY;
            S_BUSY: if (done)   state_d = S_IDLE;
            default:            state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        req_d  = req;
        cnt_d  = cnt_q;
        addr_d = addr_q;
        din_d  = din_q;
        we_d   = we_q;
        dout_d = dout_q;
        if (accept) begin
            cnt_d  = LAT_M1;
            addr_d = bus.ADDR[ADDR_W-1:0];
            din_d  = bus.DIN;
            // A simultaneous WE/RREQ edge is a write.
            we_d   = bus.WE;
        end else if (state_q == S_BUSY && !done) begin
            cnt_d = cnt_q - 8'd1;
        end
        if (done && !we_q) begin
            dout_d = mem[addr_q];
        end
`ifdef MAIN_MEM_WRITE_ECHO_EN
        if (done && we_q) begin
            dout_d = din_q;
        end
`endif
    end

    // Outputs
    always_comb begin
        bus.RDY  = (state_q == S_IDLE);
        bus.DOUT = dout_q;
    end
endmodule

// File: tb/tb_main_mem_responder.sv
// Directed self-checking bench for main_mem_responder.
// Covers latency, edge detection, collisions, aliasing, async reset and LATENCY=1.
module tb_main_mem_responder;
    localparam int L0 = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    main_mem_responder_if i0 ();
    main_mem_responder_if i1 ();

    main_mem_responder #(.ADDR_W(8), .LATENCY(L0)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (i0.slave)
    );

    main_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (i1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts one access on i0 and counts RDY-low cycles, bounded.
    task automatic access(input logic w, input logic r,
                          input logic [31:0] a, input logic [31:0] d,
                          input int hold, input int pulse_at,
                          output int busy);
        int k;
        @(negedge clk);
        i0.WE   = w;
        i0.RREQ = r;
        i0.ADDR = a;
        i0.DIN  = d;
        busy = 0;
        k = 0;
        repeat (40) begin
            @(negedge clk);
            k++;
            if (k >= hold) begin
                i0.WE   = 1'b0;
                i0.RREQ = 1'b0;
                i0.ADDR = ~a;
                i0.DIN  = ~d;
            end
            if (pulse_at != 0 && k == pulse_at) i0.RREQ = 1'b1;
            if (i0.RDY) break;
            busy++;
        end
        i0.WE   = 1'b0;
        i0.RREQ = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int b;
        access(1'b1, 1'b0, a, d, 1, 0, b);
        check("wr_busy", 32'(b), 32'(L0));
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        int b;
        access(1'b0, 1'b1, a, 32'h0, 1, 0, b);
        check("rd_busy", 32'(b), 32'(L0));
        check("rd_dout", i0.DOUT, exp);
    endtask

    initial begin
        int b;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        {i0.WE, i0.RREQ, i0.ADDR, i0.DIN} = '0;
        {i1.WE, i1.RREQ, i1.ADDR, i1.DIN} = '0;
        repeat (2) @(negedge clk);
        check("rst_rdy", 32'(i0.RDY), 32'd1);
        check("rst_dout", i0.DOUT, 32'd0);
        rst_n = 1'b1;

        access(1'b1, 1'b0, 32'd22, 32'hFFFFE8CA, 2, 0, b);
        check("wr22_busy", 32'(b), 32'd4);
        rd(32'd22, 32'hFFFFE8CA);

        access(1'b1, 1'b0, 32'd30, 32'd1, 6, 0, b);
        check("hold6_busy", 32'(b), 32'd4);
        @(negedge clk);
        check("no_retrig", 32'(i0.RDY), 32'd1);

        for (int i = 0; i < 10; i++) wr(32'(i), 32'(-i));
        for (int i = 0; i < 10; i++) rd(32'(i), 32'(-i));

        access(1'b1, 1'b1, 32'd5, 32'd77, 1, 0, b);
        check("coll_busy", 32'(b), 32'd4);
`ifdef MAIN_MEM_WRITE_ECHO_EN
        check("coll_dout", i0.DOUT, 32'd77);
`else
        check("coll_dout", i0.DOUT, 32'hFFFFFFF7);
`endif
        rd(32'd5, 32'd77);

        wr(32'h105, 32'd123);
        access(1'b0, 1'b1, 32'h005, 32'h0, 1, 2, b);
        check("alias_busy", 32'(b), 32'd4);
        check("alias_dout", i0.DOUT, 32'd123);
        @(negedge clk);
        check("pulse_drop", 32'(i0.RDY), 32'd1);

        wr(32'd3, 32'd11);
        @(negedge clk);
        i0.WE   = 1'b1;
        i0.ADDR = 32'd3;
        i0.DIN  = 32'd99;
        @(negedge clk);
        i0.WE = 1'b0;
        check("pre_rst_busy", 32'(i0.RDY), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_rdy", 32'(i0.RDY), 32'd1);
        check("arst_dout", i0.DOUT, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(32'd3, 32'd11);

        wr(32'd4, 32'd8);
        rd(32'd4, 32'd8);
        wr(32'd6, 32'd55);
`ifdef MAIN_MEM_WRITE_ECHO_EN
        check("echo_dout", i0.DOUT, 32'd55);
`else
        check("echo_dout", i0.DOUT, 32'd8);
`endif

        @(negedge clk);
        i1.WE   = 1'b1;
        i1.ADDR = 32'd7;
        i1.DIN  = 32'd42;
        @(negedge clk);
        i1.WE = 1'b0;
        check("l1_wr_busy", 32'(i1.RDY), 32'd0);
        @(negedge clk);
        check("l1_wr_done", 32'(i1.RDY), 32'd1);
        @(negedge clk);
        i1.RREQ = 1'b1;
        @(negedge clk);
        i1.RREQ = 1'b0;
        check("l1_rd_busy", 32'(i1.RDY), 32'd0);
        @(negedge clk);
        check("l1_rd_done", 32'(i1.RDY), 32'd1);
        check("l1_rd_dout", i1.DOUT, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Word-addressed backing-memory responder for the cache/CPU memory protocol: it accepts a single read (`RREQ`) or write (`WE`) request, holds `RDY` low for a fixed configurable latency, and then completes the access. It sits on the far side of the ADDR/DIN/WE/RREQ/DOUT/RDY handshake. Its uses are:
- slow main memory behind `CacheTop` for refill and write-back;
- a stand-alone latency-accurate memory model for protocol benches.

## Interface
- `ADDR_W`, 8: word-index bits; storage depth is 2^ADDR_W 32-bit words.
- `LATENCY`, 4: cycles from request acceptance to completion; legal range 1..255.
- `CLK` in 1: single clock, rising-edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `ADDR` in 32: word address; only `ADDR[ADDR_W-1:0]` is used, upper bits are ignored (aliasing).
- `DIN` in 32: write data.
- `WE` in 1: write request level.
- `RREQ` in 1: read request level.
- `DOUT` out 32: read data, valid while `RDY`=1 after a read completes.
- `RDY` out 1: 1 = idle/complete, 0 = busy.

## Operation
- States:
  - IDLE: `RDY`=1.
  - BUSY: `RDY`=0; an 8-bit down-counter runs.
- Request detection is edge-based:
  - `req = WE | RREQ` is registered as `req_q`.
  - A request is accepted on a rising edge where `req & ~req_q & RDY`.
  - Holding `WE`/`RREQ` high for several cycles produces exactly one access.
- On acceptance:
  - latch `ADDR[ADDR_W-1:0]`, `DIN`, and the op type;
  - load counter with `LATENCY-1`;
  - go to BUSY.
- Input changes after acceptance have no effect on the access.
- If `WE` and `RREQ` rise in the same cycle, the access is a write; no read is performed.
- BUSY behaviour:
  - the counter decrements each cycle;
  - when it reaches 0, the access completes on that edge and the state returns to IDLE.
- Read completion: `DOUT` ← mem[latched index], `RDY` ← 1.
- Write completion:
  - mem[latched index] ← latched `DIN`;
  - `RDY` ← 1;
  - `DOUT` per Configuration.
- A rising request edge while BUSY is dropped, not queued.
  - `req_q` still tracks the input, so a level held across completion does not retrigger.
- Outside of completions `DOUT` holds its last value.
- Reset (asserted asynchronously, at any time including mid-access):
  - state IDLE, `RDY`=1, `DOUT`=0, `req_q`=0, counter 0;
  - an in-flight write is abandoned and memory is not modified.
- Reset does not clear memory contents.
- After reset release, a request already held high is accepted on the first edge, because `req_q`=0.
- Read of a never-written word returns an X/undefined value. Benches write before reading.

## Timing
- Edge E0 samples the rising request and accepts it; `RDY` goes low after E0.
- `RDY` returns high and read `DOUT` is valid after edge E0+`LATENCY`.
- With `LATENCY`=1, `RDY` is low for exactly one cycle.
- The write becomes visible to a read accepted at or after E0+`LATENCY`+1.
- Back-to-back throughput: one access per `LATENCY`+1 cycles minimum. The request must drop for at least one cycle between accesses.
- No combinational path from inputs to outputs.

## Configuration
- `MAIN_MEM_WRITE_ECHO_EN` defined: on write completion, `DOUT` ← the written data, which serves as a read-back confirmation.
- `MAIN_MEM_WRITE_ECHO_EN` undefined: `DOUT` is unchanged by writes and keeps the last read data (or 0 after reset).
- `RDY` timing is identical in both builds.

## Test plan
- Reset, then write 22←-5942 (`WE` held 2 cycles), then read 22 with `LATENCY`=4 -> `RDY` low exactly 4 cycles for each access, exactly one write, read `DOUT`=32'hFFFFE8CA.
- Write i←-i for i=0..9, then read 0..9 -> `DOUT`=-i for each; `RDY` never rises early.
- `WE` and `RREQ` rise together (addr 5, data 77) -> treated as a write; a subsequent read of 5 returns 77; the first cycle after the collision performs no read.
- With `ADDR_W`=8, write 0x105←123, then read 0x005 -> 123 (alias). A second request edge pulsed mid-BUSY is ignored and the BUSY window is unchanged.
- Write 3←11 and complete it; start write 3←99; assert `RST_N`=0 two cycles into BUSY -> `RDY`=1 and `DOUT`=0 immediately (async); after release, read 3 -> 11.
- Build with and without `MAIN_MEM_WRITE_ECHO_EN`: read 4 (value 8), then write 6←55 -> `DOUT`=55 after the write when defined, `DOUT`=8 when undefined. Also run `LATENCY`=1 -> single-cycle BUSY.
